dpcm_mc_encoder: RTL and testbench
==================================

Name: dpcm_mc_encoder

Overview:
- Multi-channel, parametrised DPCM encoder for streaming sample data.
- Keeps one predictor (previous sample) per channel and emits the difference between each new sample and that channel's previous sample.
- Output is either a signed difference or a magnitude plus sign flag.
- Sits between a sample source and a packer/entropy stage. Both sides use valid/ready handshakes, with an output FIFO to absorb backpressure.

Parameters:
- WIDTH, 32, sample width in bits (>= 2).
- CHANNELS, 4, number of independent predictor channels (>= 1).
- MODE, 0, 0 = signed two's-complement difference; 1 = absolute magnitude plus out_neg flag.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).
- CH_W, max(1, clog2(CHANNELS)), channel index width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- in_chan  input  CH_W  channel index of in_data.
- in_first  input  1  sample starts a new sequence: predictor is treated as 0 for this sample.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts FIFO head.
- out_data  output  WIDTH+1  difference (sign-extended in MODE 0; zero-extended magnitude in MODE 1).
- out_neg  output  1  MODE 1: difference was negative; MODE 0: copy of out_data MSB.
- out_chan  output  CH_W  channel of out_data.
- err_chan  output  1  sticky: a sample with in_chan >= CHANNELS was accepted.

Behaviour:
- Reset: synchronous, active-high, clock clk; takes effect at the next rising edge and overrides all activity, including mid-transfer.
  - Predictors = 0; primed bits = 0; FIFO emptied.
  - Outputs after reset: out_valid=0, out_data=0, out_neg=0, out_chan=0, err_chan=0, in_ready=1.
- Input handshake:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - in_ready = !fifo_full, registered-count based; no same-cycle pop bypass.
  - in_data, in_chan and in_first are sampled only on accept.
- Predictor and difference: on accept with valid channel c:
  - pred = (in_first | !primed[c]) ? 0 : prev[c].
  - diff = {1'b0,in_data} - {1'b0,pred}, computed in WIDTH+1 bits; never overflows.
  - prev[c] <= in_data; primed[c] <= 1.
  - Other channels are untouched.
- MODE 0: out_data = diff; out_neg = diff[WIDTH].
- MODE 1:
  - out_data = diff negative ? -diff : diff, with MSB always 0.
  - out_neg = 1 only when diff < 0; equal samples give out_data=0, out_neg=0.
- Invalid channel (in_chan >= CHANNELS):
  - Sample is accepted and discarded: no FIFO push, no predictor change.
  - err_chan <= 1 and stays set until rst.
- Latency:
  - Accepted sample is pushed into the FIFO at the accept edge.
  - out_valid rises the following cycle if the FIFO was empty; 1 cycle accept-to-out_valid.
  - Throughput is 1 sample/cycle while out_ready=1.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full: in_ready=0 until the cycle after a pop.
  - Empty: out_valid=0; out_data/out_neg/out_chan hold the last popped value (0 after reset).
  - Pointers wrap modulo FIFO_DEPTH; strict FIFO order across channels.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_neg/out_chan remain stable.
- Wrap-around samples: max-to-0 transition gives diff = -(2^WIDTH-1), representable in WIDTH+1 bits.

Test Plan:
- Reset mid-stream:
  - Stimulus (WIDTH=8, CHANNELS=2, MODE 0): fill FIFO with 3 entries, assert rst for 1 cycle.
  - Response: out_valid=0, in_ready=1, err_chan=0. Next ch0 sample 20 yields out_data=20, proving the predictor was cleared.
- Signed differences:
  - Stimulus (MODE 0, out_ready=1): ch0 samples 10, 25, 5.
  - Response: out_data = 10, 15, -20 (9'h1EC); out_neg = 0, 0, 1; each appears 1 cycle after accept.
- Channel interleave and in_first:
  - Stimulus: ch0=100, ch1=50, ch0=90, ch1=60; then ch1=70 with in_first=1.
  - Response: outputs 100, 50, -10, 10, then 70; out_chan follows the inputs.
- Magnitude mode and extremes:
  - Stimulus (MODE 1): ch0 samples 255, 0, 0.
  - Response: out_data = 255, 255, 0; out_neg = 0, 1, 0.
- Backpressure and FIFO:
  - Stimulus (FIFO_DEPTH=4): hold out_ready=0, drive 6 samples.
  - Response: 4 accepted, then in_ready=0 and out_data stays stable.
  - Then release out_ready with in_valid=1; simultaneous push/pop keeps count constant; all 6 results emerge in order with no loss or duplication.
- Invalid channel:
  - Stimulus (CHANNELS=3, CH_W=2): sample on in_chan=3.
  - Response: accepted with in_ready=1, no output, err_chan=1 sticky. Predictors of ch0–2 are unchanged, verified by the next ch0 difference.

Source files
------------

// File: rtl/dpcm_mc_encoder.sv
// rtl/dpcm_mc_encoder.sv - multi-channel DPCM encoder with per-channel predictors and output FIFO
// Emits (sample - previous sample of same channel) as signed diff or magnitude+sign.
module dpcm_mc_encoder #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]  in_chan,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_neg,
  output logic [CH_W-1:0]  out_chan,
  output logic             err_chan
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NP = 2 ** CH_W;

  logic [WIDTH-1:0] r_prev [NP];
  logic [NP-1:0]    r_primed;
  logic             r_err;

  logic [WIDTH:0]   r_mem_data [FIFO_DEPTH];
  logic             r_mem_neg  [FIFO_DEPTH];
  logic [CH_W-1:0]  r_mem_chan [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH:0]   r_last_data;
  logic             r_last_neg;
  logic [CH_W-1:0]  r_last_chan;

  logic             w_chan_ok;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pred;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_res;

  // Widen by one bit so CHANNELS itself fits when it is a power of two.
  assign w_chan_ok = ({1'b0, in_chan} < (CH_W + 1)'(CHANNELS));
  assign in_ready  = (r_count != (AW + 1)'(FIFO_DEPTH));
  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & w_chan_ok;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;

  assign w_pred = (in_first || !r_primed[in_chan]) ? '0 : r_prev[in_chan];
  assign w_diff = {1'b0, in_data} - {1'b0, w_pred};
  // Magnitude of a WIDTH+1 bit difference never exceeds 2^WIDTH-1, so MSB stays 0.
  assign w_res  = (MODE == 1 && w_diff[WIDTH]) ? -w_diff : w_diff;

  assign out_data = out_valid ? r_mem_data[r_rd_ptr] : r_last_data;
  assign out_neg  = out_valid ? r_mem_neg[r_rd_ptr]  : r_last_neg;
  assign out_chan = out_valid ? r_mem_chan[r_rd_ptr] : r_last_chan;
  assign err_chan = r_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_res;
      r_mem_neg[r_wr_ptr]  <= w_diff[WIDTH];
      r_mem_chan[r_wr_ptr] <= in_chan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) r_prev[i] <= '0;
      r_primed    <= '0;
      r_err       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_data <= '0;
      r_last_neg  <= 1'b0;
      r_last_chan <= '0;
    end else begin
      if (w_push) begin
        r_prev[in_chan]   <= in_data;
        r_primed[in_chan] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_accept && !w_chan_ok) r_err <= 1'b1;
      if (w_pop) begin
        r_last_data <= r_mem_data[r_rd_ptr];
        r_last_neg  <= r_mem_neg[r_rd_ptr];
        r_last_chan <= r_mem_chan[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dpcm_mc_encoder.sv
// tb/tb_dpcm_mc_encoder.sv - directed bench for dpcm_mc_encoder (signed and magnitude instances)
module tb_dpcm_mc_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_chan;
  logic       in_first;
  logic       out_ready;

  logic       s_in_ready, s_out_valid, s_out_neg, s_err_chan;
  logic [8:0] s_out_data;
  logic [1:0] s_out_chan;
  logic       m_in_ready, m_out_valid, m_out_neg, m_err_chan;
  logic [8:0] m_out_data;
  logic [1:0] m_out_chan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpcm_mc_encoder #(.WIDTH(8), .CHANNELS(3), .MODE(0), .FIFO_DEPTH(4)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_chan(in_chan), .in_first(in_first),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_neg(s_out_neg), .out_chan(s_out_chan), .err_chan(s_err_chan)
  );

  dpcm_mc_encoder #(.WIDTH(8), .CHANNELS(3), .MODE(1), .FIFO_DEPTH(4)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_chan(in_chan), .in_first(in_first),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_neg(m_out_neg), .out_chan(m_out_chan), .err_chan(m_err_chan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic f);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = d;
    in_first = f;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  logic [7:0] bp_in  [6] = '{8'd10, 8'd30, 8'd35, 8'd70, 8'd71, 8'd100};
  logic [8:0] bp_exp [6] = '{9'd10, 9'd20, 9'd5, 9'd35, 9'd1, 9'd29};
  logic [8:0] bp_got [6];

  initial begin
    int k, n, acc_cnt, cyc;
    logic acc, pop;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chan = '0; in_first = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_in_ready",  s_in_ready, 1);
    chk("rst_err_chan",  s_err_chan, 0);
    chk("rst_out_data",  s_out_data, 0);
    chk("rst_out_chan",  s_out_chan, 0);

    // Reset mid-stream with three entries queued.
    send(0, 8'd1, 0); send(0, 8'd2, 0); send(0, 8'd3, 0);
    chk("pre_rst_valid", s_out_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_out_valid", s_out_valid, 0);
    chk("mid_rst_in_ready",  s_in_ready, 1);
    chk("mid_rst_err",       s_err_chan, 0);
    out_ready = 1'b1;
    send(0, 8'd20, 0);
    chk("post_rst_data",  s_out_data, 9'd20);
    chk("post_rst_valid", s_out_valid, 1);

    // Signed differences on ch0.
    send(0, 8'd10, 1);
    chk("sd0_data", s_out_data, 9'd10);   chk("sd0_neg", s_out_neg, 0);
    send(0, 8'd25, 0);
    chk("sd1_data", s_out_data, 9'd15);   chk("sd1_neg", s_out_neg, 0);
    send(0, 8'd5, 0);
    chk("sd2_data", s_out_data, 9'h1EC);  chk("sd2_neg", s_out_neg, 1);
    chk("sd2_mag",  m_out_data, 9'd20);   chk("sd2_mneg", m_out_neg, 1);

    // Channel interleave and in_first.
    send(0, 8'd100, 1);
    chk("il0_data", s_out_data, 9'd100);  chk("il0_chan", s_out_chan, 0);
    send(1, 8'd50, 0);
    chk("il1_data", s_out_data, 9'd50);   chk("il1_chan", s_out_chan, 1);
    send(0, 8'd90, 0);
    chk("il2_data", s_out_data, 9'h1F6);  chk("il2_chan", s_out_chan, 0);
    send(1, 8'd60, 0);
    chk("il3_data", s_out_data, 9'd10);   chk("il3_chan", s_out_chan, 1);
    send(1, 8'd70, 1);
    chk("il4_data", s_out_data, 9'd70);   chk("il4_chan", s_out_chan, 1);

    // Magnitude mode and extremes.
    send(0, 8'd255, 1);
    chk("mg0_data", m_out_data, 9'd255);  chk("mg0_neg", m_out_neg, 0);
    send(0, 8'd0, 0);
    chk("mg1_data", m_out_data, 9'd255);  chk("mg1_neg", m_out_neg, 1);
    chk("wrap_signed", s_out_data, 9'h101);
    send(0, 8'd0, 0);
    chk("mg2_data", m_out_data, 9'd0);    chk("mg2_neg", m_out_neg, 0);
    tick();
    chk("drained", s_out_valid, 0);

    // Backpressure: six samples on ch1, out_ready low.
    out_ready = 1'b0;
    k = 0; acc_cnt = 0;
    in_valid = 1'b1; in_chan = 2'd1; in_data = bp_in[0]; in_first = 1'b1;
    for (int c = 0; c < 6; c++) begin
      acc = in_valid & s_in_ready;
      tick();
      if (acc) begin k++; acc_cnt++; end
      in_data = bp_in[k]; in_first = (k == 0);
    end
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_in_ready", s_in_ready, 0);
    chk("bp_stable",   s_out_data, 9'd10);
    out_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 30) begin
      acc = in_valid & s_in_ready;
      pop = s_out_valid & out_ready;
      if (pop) bp_got[n] = s_out_data;
      tick();
      cyc++;
      if (pop) n++;
      if (acc) k++;
      if (k < 6) in_data = bp_in[k];
      else in_valid = 1'b0;
    end
    chk("bp_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_order%0d", i), bp_got[i], bp_exp[i]);
    chk("bp_empty", s_out_valid, 0);
    chk("bp_hold",  s_out_data, 9'd29);

    // Invalid channel.
    chk("inv_ready", s_in_ready, 1);
    send(3, 8'd200, 0);
    chk("inv_no_out", s_out_valid, 0);
    chk("inv_err",    s_err_chan, 1);
    send(1, 8'd130, 0);
    chk("inv_ch1", s_out_data, 9'd30);
    send(0, 8'd7, 0);
    chk("inv_ch0", s_out_data, 9'd7);
    tick();
    chk("inv_sticky", s_err_chan, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("inv_cleared", s_err_chan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
